backward_delta: RTL and testbench
=================================

Name: backward_delta

Overview:
- Stage directly downstream of the backward multiply-accumulate: consumes the NC per-lane accumulated error sums and applies the ReLU derivative, masking each lane by the stored forward activation of the same layer.
- Saturates each sum to WV bits and emits the delta vector for the previous layer's backward pass and weight update.
- Joins two valid/ready streams, then one registered output stage; a sticky saturation counter supports debug and fixed-point tuning.

Parameters:
- NN, 7, neuron count of the following layer; sets accumulator growth.
- NC, 11, lane count (neurons of this layer).
- WV, 5, signed value width of activations and deltas.
- BURST, "yes", "yes" = full throughput (ready has a combinational path from downstream); "no" = ready registered-only, half throughput.
- WA (localparam), $clog2(NN)+WV, signed accumulator lane width.

Ports:
- iCLK  input  1  clock, rising edge.
- iRST  input  1  asynchronous, active-low reset.
- iValid_AM_Accum2  input  1  accumulator stream valid.
- oReady_AM_Accum2  output  1  accumulator stream ready.
- iData_AM_Accum2  input  NC*WA  lane i at bits [i*WA +: WA], signed.
- iValid_AM_Actv  input  1  stored forward activation valid.
- oReady_AM_Actv  output  1  activation ready.
- iData_AM_Actv  input  NC*WV  lane i at bits [i*WV +: WV], signed.
- oValid_BM_Delta1  output  1  delta valid.
- iReady_BM_Delta1  input  1  downstream ready.
- oData_BM_Delta1  output  NC*WV  lane i at bits [i*WV +: WV], signed delta.
- oSatCount  output  16  transfers with at least one saturated lane.

Behaviour:
- Reset (iRST=0, async): oValid_BM_Delta1=0, oData_BM_Delta1=0, oSatCount=0. Takes effect immediately mid-operation; any held result is discarded.
- Stage free: free = !oValid | iReady when BURST="yes"; free = !oValid when BURST="no".
- Join: fire = iValid_Accum2 & iValid_Actv & free.
  - oReady_AM_Accum2 = iValid_Actv & free.
  - oReady_AM_Actv = iValid_Accum2 & free.
  - Neither stream is consumed alone. A valid on one stream with the other idle holds that input; its data must stay stable.
- Per lane, combinational before the register:
  - s = sat(accum): accum > 2^(WV-1)-1 gives 2^(WV-1)-1; accum < -2^(WV-1) gives -2^(WV-1); otherwise accum[WV-1:0].
  - delta = (actv > 0) ? s : 0. Activation 0 counts as non-positive.
  - lanesat = (accum out of range) & (actv > 0). A masked lane never counts as saturated.
- On fire: output register loads all delta lanes; oValid=1. Latency 1 cycle from fire to oValid.
- Output drain:
  - iReady & oValid & !fire: oValid goes to 0; data holds its last value.
  - fire & iReady in the same cycle (BURST="yes"): register reloads and oValid stays 1 (back-to-back, 1 transfer/cycle).
  - BURST="no": at most 1 transfer per 2 cycles.
- Output hold: while oValid & !iReady, data and valid stay stable (AXI-style; no retraction).
- oSatCount: increments by 1 on a fire where any lanesat=1. Saturates at 16'hFFFF with no wrap. Cleared only by reset.

Decomposition:
- Shared package holds:
  - the lane-width function (clog2(NN)+WV);
  - a signed saturate function sat(value, WA, WV);
  - a relu_pos predicate;
  - 16-bit counter width constant SAT_CNT_W.
- One natural sub-module: delta_lane. Purely combinational, one lane: saturate + mask + lanesat flag, instantiated NC times via generate.
- Join, output register and counter live in the top.

Test Plan:
All with NN=4, NC=2, WV=5 (WA=7), unless stated.
- Pass/clip: accum lanes {20,-20}, actv {3,1}, iReady=1 -> next cycle oValid=1, delta {15,-16}, oSatCount=1.
- Masking: accum {9,-40}, actv {0,-2} -> delta {0,0}, oSatCount unchanged. accum {9,-3}, actv {1,7} -> delta {9,-3}.
- Join:
  - Accum2 valid for 3 cycles with Actv low -> both readies stay 0 with Actv low, no output.
  - Actv rises -> single fire, both readies 1 for that cycle, oValid next cycle.
- Backpressure/throughput:
  - iReady=0 for 4 cycles -> output stable, readies 0 while oValid=1.
  - BURST="yes" with iReady=1 and 8 back-to-back inputs -> 8 outputs in 8 consecutive cycles.
  - BURST="no" -> same 8 outputs take 16 cycles.
- Counter saturation: force 65537 saturating fires -> oSatCount holds 16'hFFFF.
- Reset mid-operation: assert iRST=0 while oValid=1 with iReady=0 -> oValid, oData and oSatCount go to 0 asynchronously, before the next clock edge.

Source files
------------

// File: rtl/backward_delta_pkg.sv
// Shared helpers for the backward delta stage: lane width, saturation, ReLU predicate.
package backward_delta_pkg;

    localparam int unsigned SAT_CNT_W = 16;

    function automatic int unsigned lane_width(input int unsigned nn, input int unsigned wv);
        return $clog2(nn) + wv;
    endfunction

    // value carries a WA-bit signed quantity; result is clamped to the WV-bit signed range
    function automatic logic signed [31:0] sat(input logic signed [31:0] value,
                                               input int unsigned       wa,
                                               input int unsigned       wv);
        logic signed [31:0] v;
        logic signed [31:0] hi;
        logic signed [31:0] lo;
        v  = (value <<< (32 - wa)) >>> (32 - wa);
        hi = (32'sd1 <<< (wv - 1)) - 32'sd1;
        lo = -hi - 32'sd1;
        if (v > hi) begin
            return hi;
        end
        if (v < lo) begin
            return lo;
        end
        return v;
    endfunction

    function automatic logic relu_pos(input logic signed [31:0] a);
        return a > 32'sd0;
    endfunction

endpackage

// File: rtl/backward_delta_delta_lane.sv
// One lane of the delta stage: saturate the accumulated error, mask by ReLU derivative.
module delta_lane
    import backward_delta_pkg::*;
#(
    parameter int unsigned WA = 7,
    parameter int unsigned WV = 5
) (
    input  logic signed [WA-1:0] i_accum,
    input  logic signed [WV-1:0] i_actv,
    output logic signed [WV-1:0] o_delta,
    output logic                 o_lanesat
);

    logic signed [31:0] w_accum_ext;
    logic signed [31:0] w_actv_ext;
    logic signed [31:0] w_sat;
    logic               w_pos;
    logic               w_oor;

    always_comb begin
        w_accum_ext = 32'(i_accum);
        w_actv_ext  = 32'(i_actv);
        w_sat       = sat(w_accum_ext, WA, WV);
        w_pos       = relu_pos(w_actv_ext);
        w_oor       = (w_sat != w_accum_ext);
        o_delta     = w_pos ? w_sat[WV-1:0] : '0;
        o_lanesat   = w_oor & w_pos;
    end

endmodule

// File: rtl/backward_delta.sv
// Backward delta stage: joins accumulator and activation streams, applies ReLU mask
// and saturation per lane, registers the delta vector and counts saturating transfers.
module backward_delta
    import backward_delta_pkg::*;
#(
    parameter int unsigned  NN    = 7,
    parameter int unsigned  NC    = 11,
    parameter int unsigned  WV    = 5,
    parameter string        BURST = "yes",
    localparam int unsigned WA    = lane_width(NN, WV)
) (
    input  logic                 iCLK,
    input  logic                 iRST,
    input  logic                 iValid_AM_Accum2,
    output logic                 oReady_AM_Accum2,
    input  logic [NC*WA-1:0]     iData_AM_Accum2,
    input  logic                 iValid_AM_Actv,
    output logic                 oReady_AM_Actv,
    input  logic [NC*WV-1:0]     iData_AM_Actv,
    output logic                 oValid_BM_Delta1,
    input  logic                 iReady_BM_Delta1,
    output logic [NC*WV-1:0]     oData_BM_Delta1,
    output logic [SAT_CNT_W-1:0] oSatCount
);

    localparam bit BURST_EN = (BURST == "yes");

    logic                 r_valid;
    logic [NC*WV-1:0]     r_data;
    logic [SAT_CNT_W-1:0] r_sat_cnt;

    logic                 w_free;
    logic                 w_fire;
    logic                 w_any_sat;
    logic [NC*WV-1:0]     w_delta;
    logic [NC-1:0]        w_lanesat;

    for (genvar g = 0; g < NC; g++) begin : g_lane
        delta_lane #(
            .WA (WA),
            .WV (WV)
        ) u_lane (
            .i_accum   (iData_AM_Accum2[g*WA +: WA]),
            .i_actv    (iData_AM_Actv[g*WV +: WV]),
            .o_delta   (w_delta[g*WV +: WV]),
            .o_lanesat (w_lanesat[g])
        );
    end

    // Without burst the register only accepts when empty, trading throughput for a registered ready
    always_comb begin
        w_free    = BURST_EN ? (!r_valid || iReady_BM_Delta1) : !r_valid;
        w_fire    = iValid_AM_Accum2 && iValid_AM_Actv && w_free;
        w_any_sat = |w_lanesat;
    end

    assign oReady_AM_Accum2 = iValid_AM_Actv && w_free;
    assign oReady_AM_Actv   = iValid_AM_Accum2 && w_free;

    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (w_fire) begin
            r_valid <= 1'b1;
            r_data  <= w_delta;
        end else if (r_valid && iReady_BM_Delta1) begin
            r_valid <= 1'b0;
        end
    end

    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            r_sat_cnt <= '0;
        end else if (w_fire && w_any_sat && (r_sat_cnt != '1)) begin
            r_sat_cnt <= r_sat_cnt + 1'b1;
        end
    end

    assign oValid_BM_Delta1 = r_valid;
    assign oData_BM_Delta1  = r_data;
    assign oSatCount        = r_sat_cnt;

endmodule

// File: tb/tb_backward_delta.sv
// Bench for backward_delta: a burst and a half-rate instance checked every cycle
// against an arithmetic reference model, plus directed literal checks.
module tb_backward_delta;

    localparam int unsigned NN = 4;
    localparam int unsigned NC = 2;
    localparam int unsigned WV = 5;
    localparam int unsigned WA = 7;

    logic clk = 1'b0;
    logic rst_n;

    logic             va [2];
    logic             vb [2];
    logic             rdy[2];
    logic             ra [2];
    logic             rb [2];
    logic             ov [2];
    logic [NC*WA-1:0] da [2];
    logic [NC*WV-1:0] db [2];
    logic [NC*WV-1:0] od [2];
    logic [15:0]      sc [2];

    int n_pass  = 0;
    int n_total = 0;
    int hs[2]   = '{0, 0};

    bit          mv[2]   = '{0, 0};
    logic [9:0]  md[2]   = '{10'd0, 10'd0};
    int          mcnt[2] = '{0, 0};

    always #5 clk = ~clk;

    backward_delta #(.NN(NN), .NC(NC), .WV(WV), .BURST("yes")) u_dut_burst (
        .iCLK(clk), .iRST(rst_n),
        .iValid_AM_Accum2(va[0]), .oReady_AM_Accum2(ra[0]), .iData_AM_Accum2(da[0]),
        .iValid_AM_Actv(vb[0]), .oReady_AM_Actv(rb[0]), .iData_AM_Actv(db[0]),
        .oValid_BM_Delta1(ov[0]), .iReady_BM_Delta1(rdy[0]), .oData_BM_Delta1(od[0]),
        .oSatCount(sc[0])
    );

    backward_delta #(.NN(NN), .NC(NC), .WV(WV), .BURST("no")) u_dut_half (
        .iCLK(clk), .iRST(rst_n),
        .iValid_AM_Accum2(va[1]), .oReady_AM_Accum2(ra[1]), .iData_AM_Accum2(da[1]),
        .iValid_AM_Actv(vb[1]), .oReady_AM_Actv(rb[1]), .iData_AM_Actv(db[1]),
        .oValid_BM_Delta1(ov[1]), .iReady_BM_Delta1(rdy[1]), .oData_BM_Delta1(od[1]),
        .oSatCount(sc[1])
    );

    function automatic int lane_a(input logic [13:0] a, input int i);
        logic [6:0] f;
        f = a[i*7 +: 7];
        return int'($signed(f));
    endfunction

    function automatic int lane_b(input logic [9:0] b, input int i);
        logic [4:0] f;
        f = b[i*5 +: 5];
        return int'($signed(f));
    endfunction

    function automatic logic [9:0] exp_delta(input logic [13:0] a, input logic [9:0] b);
        logic [9:0] r;
        int d;
        r = '0;
        for (int i = 0; i < 2; i++) begin
            d = 0;
            if (lane_b(b, i) > 0) begin
                d = lane_a(a, i);
                if (d > 15)  d = 15;
                if (d < -16) d = -16;
            end
            r[i*5 +: 5] = d[4:0];
        end
        return r;
    endfunction

    function automatic bit exp_sat(input logic [13:0] a, input logic [9:0] b);
        bit s;
        s = 0;
        for (int i = 0; i < 2; i++) begin
            if (lane_b(b, i) > 0 && (lane_a(a, i) > 15 || lane_a(a, i) < -16)) s = 1;
        end
        return s;
    endfunction

    function automatic logic [13:0] pa(input int l0, input int l1);
        logic [13:0] r;
        r[6:0]  = l0[6:0];
        r[13:7] = l1[6:0];
        return r;
    endfunction

    function automatic logic [9:0] pb(input int l0, input int l1);
        logic [9:0] r;
        r[4:0] = l0[4:0];
        r[9:5] = l1[4:0];
        return r;
    endfunction

    task automatic check(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s[%0d]: got %0h, expected %0h at %0t", nm, k, act, exp, $time);
        else n_pass++;
    endtask

    // Reference model: one transfer per join when the output slot is free
    initial begin
        bit mfree;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                for (int k = 0; k < 2; k++) begin
                    mv[k] = 0; md[k] = '0; mcnt[k] = 0;
                end
            end else begin
                for (int k = 0; k < 2; k++) begin
                    mfree = !mv[k] || (k == 0 && rdy[k]);
                    if (va[k] && vb[k] && mfree) begin
                        mv[k] = 1;
                        md[k] = exp_delta(da[k], db[k]);
                        if (exp_sat(da[k], db[k]) && mcnt[k] < 65535) mcnt[k]++;
                    end else if (mv[k] && rdy[k]) begin
                        mv[k] = 0;
                    end
                end
            end
        end
    end

    initial begin
        bit cfree;
        forever begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                cfree = !mv[k] || (k == 0 && rdy[k]);
                check("valid", k, ov[k], mv[k]);
                check("data", k, od[k], md[k]);
                check("satcnt", k, sc[k], mcnt[k]);
                check("ready_accum", k, ra[k], vb[k] && cfree);
                check("ready_actv", k, rb[k], va[k] && cfree);
                if (ov[k] && rdy[k]) hs[k]++;
            end
        end
    end

    task automatic set_in(input logic v_a, input logic v_b, input logic r,
                          input logic [13:0] a, input logic [9:0] b);
        for (int k = 0; k < 2; k++) begin
            va[k] = v_a; vb[k] = v_b; rdy[k] = r; da[k] = a; db[k] = b;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offered data is held until taken; a fresh offer is drawn only after acceptance
    task automatic step(input int pv, input int pr);
        bit ta[2];
        bit tb[2];
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            ta[k] = va[k] && ra[k];
            tb[k] = vb[k] && rb[k];
        end
        @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            if (!va[k] || ta[k]) begin
                va[k] = int'($urandom_range(99, 0)) < pv;
                da[k] = 14'($urandom);
            end
            if (!vb[k] || tb[k]) begin
                vb[k] = int'($urandom_range(99, 0)) < pv;
                db[k] = 10'($urandom);
            end
            rdy[k] = int'($urandom_range(99, 0)) < pr;
        end
    endtask

    initial begin
        rst_n = 1'b0;
        set_in(0, 0, 0, '0, '0);
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", 0, ov[0], 0);
        check("rst_data", 0, od[0], 0);
        check("rst_cnt", 0, sc[0], 0);
        rst_n = 1'b1;

        set_in(1, 1, 1, pa(20, -20), pb(3, 1));
        tick();
        check("clip_valid", 0, ov[0], 1);
        check("clip_data", 0, od[0], 10'h20F);
        check("clip_model", 0, md[0], 10'h20F);
        check("clip_cnt", 0, sc[0], 1);

        set_in(1, 1, 1, pa(9, -40), pb(0, -2));
        tick();
        check("mask_data", 0, od[0], 10'h000);
        check("mask_cnt", 0, sc[0], 1);

        set_in(1, 1, 1, pa(9, -3), pb(1, 7));
        tick();
        check("pass_data", 0, od[0], 10'h3A9);

        set_in(1, 1, 0, pa(5, 6), pb(1, 1));
        for (int i = 0; i < 4; i++) begin
            tick();
            check("bp_valid", 0, ov[0], 1);
            check("bp_data", 0, od[0], 10'h3A9);
            check("bp_ready_accum", 0, ra[0], 0);
            check("bp_ready_actv", 0, rb[0], 0);
        end
        set_in(1, 1, 1, pa(5, 6), pb(1, 1));
        tick();
        check("bp_release", 0, od[0], 10'h0C5);

        set_in(0, 0, 1, '0, '0);
        repeat (3) tick();
        check("drain_valid", 0, ov[0], 0);

        set_in(1, 0, 1, pa(9, -3), pb(1, 7));
        for (int i = 0; i < 3; i++) begin
            tick();
            check("join_ready_accum", 0, ra[0], 0);
            check("join_valid", 0, ov[0], 0);
        end
        set_in(1, 1, 1, pa(9, -3), pb(1, 7));
        #1;
        check("join_fire_ra", 0, ra[0], 1);
        check("join_fire_rb", 0, rb[0], 1);
        tick();
        check("join_out_valid", 0, ov[0], 1);
        check("join_out_data", 0, od[0], 10'h3A9);

        set_in(0, 0, 1, '0, '0);
        tick();
        set_in(1, 1, 0, pa(20, -20), pb(3, 1));
        tick();
        check("pre_rst_valid", 0, ov[0], 1);
        check("pre_rst_data", 0, od[0], 10'h20F);
        check("pre_rst_cnt", 0, sc[0], 2);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_valid", 0, ov[0], 0);
        check("async_rst_data", 0, od[0], 0);
        check("async_rst_cnt", 0, sc[0], 0);
        @(posedge clk);
        #1;
        set_in(0, 0, 0, '0, '0);
        rst_n = 1'b1;

        repeat (3000) step(70, 60);

        set_in(0, 0, 1, '0, '0);
        repeat (3) tick();
        set_in(1, 1, 1, 14'($urandom), 10'($urandom));
        hs[0] = 0;
        hs[1] = 0;
        for (int i = 1; i <= 16; i++) begin
            step(100, 100);
            if (i == 9)  check("burst_8_in_8", 0, hs[0], 8);
            if (i == 15) check("half_7_in_15", 1, hs[1], 7);
            if (i == 16) check("half_8_in_16", 1, hs[1], 8);
        end

        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        set_in(1, 1, 1, pa(40, -50), pb(1, 2));
        repeat (65534) tick();
        check("cnt_near_max", 0, sc[0], 16'hFFFE);
        repeat (3) tick();
        check("cnt_hold_max", 0, sc[0], 16'hFFFF);
        check("cnt_model_max", 0, mcnt[0], 65535);

        set_in(0, 0, 1, '0, '0);
        repeat (2) tick();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
